ddr_req_responder: RTL

DRAM-side responder for the DDR request interface driven by the packet DMA/data-mover path. It accepts write and read requests under an almost_full flow-control contract and stores write data in a local 512-bit-wide memory. Read data is returned in request order with a fixed pipeline latency, and issue is throttled by the requester's ddr_rd_resp_almost_full. It serves as the on-chip DRAM stand-in for rtl_sim and small-buffer builds, and it exports three 32-bit statistics counters.

---
 rtl/ddr_req_responder_pkg.sv | 29 ++
 rtl/ddr_req_fifo.sv | 69 ++++++
 rtl/ddr_req_responder.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/ddr_req_responder_pkg.sv
// Shared types and constants for the DDR request responder and its stats hookup.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package ddr_req_responder_pkg;

  localparam int DDR_ADDR_W = 32;
  localparam int DDR_DATA_W = 512;

  typedef struct packed {
    logic [DDR_ADDR_W-1:0] addr;
    logic [DDR_DATA_W-1:0] data;
  } ddr_wr_t;

  typedef struct packed {
    logic [DDR_ADDR_W-1:0] addr;
  } ddr_rd_t;

  // Stats register addresses for the later stats_packer hookup
  localparam logic [7:0] REG_DDR_WR   = 8'h40;
  localparam logic [7:0] REG_DDR_RD   = 8'h44;
  localparam logic [7:0] REG_DDR_DROP = 8'h48;

  // Round-robin pointer: which request class is preferred on the next contended cycle
  typedef enum logic {
    RR_WR = 1'b0,
    RR_RD = 1'b1
  } rr_e;

endpackage

// File: rtl/ddr_req_fifo.sv
// Show-ahead request queue with registered almost_full and drop-on-full.
// Latency: a push is visible at pop_data the cycle after it is sampled.
// Backpressure: none on push; a push onto a full queue without a same-cycle pop is dropped.
module ddr_req_fifo #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = 12
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             empty,
  output logic             almost_full,
  output logic             drop
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW:0]      occ_q;
  logic [PW:0]      occ_nxt;
  logic             full;
  logic             pop_ok;
  logic             accept;

  assign full     = (occ_q == (PW+1)'(DEPTH));
  assign empty    = (occ_q == '0);
  assign pop_ok   = pop && !empty;
  // A pop in the same cycle frees the slot the push needs, so full+pop still accepts
  assign accept   = push && (!full || pop_ok);
  assign drop     = push && !accept;
  assign pop_data = mem[rd_ptr];

  // Next occupancy from this cycle's accepted push and pop
  always_comb begin
    occ_nxt = occ_q;
    if (accept && !pop_ok) begin
      occ_nxt = occ_q + (PW+1)'(1);
    end else if (!accept && pop_ok) begin
      occ_nxt = occ_q - (PW+1)'(1);
    end
  end

  // Pointers, occupancy and almost_full; almost_full tracks the occupancy being entered
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      occ_q       <= '0;
      almost_full <= 1'b0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + PW'(1);
      if (pop_ok) rd_ptr <= rd_ptr + PW'(1);
      occ_q       <= occ_nxt;
      almost_full <= (occ_nxt >= (PW+1)'(AF_LEVEL));
    end
  end

  // Queue storage; contents need no reset because occupancy gates every read
  always_ff @(posedge Clk) begin
    if (accept) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/ddr_req_responder.sv
// On-chip DRAM stand-in: queued write/read requests into a 512-bit RAM, in-order read responses.
// Latency: read response exactly RD_LATENCY cycles after read grant; grant earliest the cycle after push.
// Backpressure: almost_full outputs per queue; ddr_rd_resp_almost_full stalls read issue only.
module ddr_req_responder
  import ddr_req_responder_pkg::*;
#(
  parameter int ADDR_WIDTH     = 10,
  parameter int REQ_FIFO_DEPTH = 16,
  parameter int AF_LEVEL       = 12,
  parameter int RD_LATENCY     = 2
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  ddr_wr_t               ddr_wr_req_data,
  input  logic                  ddr_wr_req_valid,
  output logic                  ddr_wr_req_almost_full,
  input  ddr_rd_t               ddr_rd_req_data,
  input  logic                  ddr_rd_req_valid,
  output logic                  ddr_rd_req_almost_full,
  output logic [DDR_DATA_W-1:0] ddr_rd_resp_data,
  output logic                  ddr_rd_resp_valid,
  input  logic                  ddr_rd_resp_almost_full,
  output logic [31:0]           stat_wr_cnt,
  output logic [31:0]           stat_rd_cnt,
  output logic [31:0]           stat_drop_cnt
);

  localparam int WR_W = ADDR_WIDTH + DDR_DATA_W;

  logic [WR_W-1:0]       wr_head;
  logic [ADDR_WIDTH-1:0] rd_head;
  logic                  wr_empty;
  logic                  rd_empty;
  logic                  wr_drop;
  logic                  rd_drop;
  logic                  wr_elig;
  logic                  rd_elig;
  logic                  wr_gnt;
  logic                  rd_gnt;
  rr_e                   rr_q;
  rr_e                   rr_nxt;
  logic                  unused_addr_hi;

  logic [DDR_DATA_W-1:0] mem [2**ADDR_WIDTH];
  logic [DDR_DATA_W-1:0] rd_dat_q [RD_LATENCY];
  logic [RD_LATENCY-1:0] rd_vld_q;

  // Request address bits above the RAM depth are intentionally ignored
  assign unused_addr_hi = ^{ddr_wr_req_data.addr[DDR_ADDR_W-1:ADDR_WIDTH],
                            ddr_rd_req_data.addr[DDR_ADDR_W-1:ADDR_WIDTH]};

  ddr_req_fifo #(
    .WIDTH    (WR_W),
    .DEPTH    (REQ_FIFO_DEPTH),
    .AF_LEVEL (AF_LEVEL)
  ) u_wr_fifo (
    .Clk         (Clk),
    .Rst_n       (Rst_n),
    .push        (ddr_wr_req_valid),
    .push_data   ({ddr_wr_req_data.addr[ADDR_WIDTH-1:0], ddr_wr_req_data.data}),
    .pop         (wr_gnt),
    .pop_data    (wr_head),
    .empty       (wr_empty),
    .almost_full (ddr_wr_req_almost_full),
    .drop        (wr_drop)
  );

  ddr_req_fifo #(
    .WIDTH    (ADDR_WIDTH),
    .DEPTH    (REQ_FIFO_DEPTH),
    .AF_LEVEL (AF_LEVEL)
  ) u_rd_fifo (
    .Clk         (Clk),
    .Rst_n       (Rst_n),
    .push        (ddr_rd_req_valid),
    .push_data   (ddr_rd_req_data.addr[ADDR_WIDTH-1:0]),
    .pop         (rd_gnt),
    .pop_data    (rd_head),
    .empty       (rd_empty),
    .almost_full (ddr_rd_req_almost_full),
    .drop        (rd_drop)
  );

  // No issue during reset so queued requests are discarded rather than committed
  assign wr_elig = Rst_n && !wr_empty;
  assign rd_elig = Rst_n && !rd_empty && !ddr_rd_resp_almost_full;

  // Arbiter state register
  always_ff @(posedge Clk) begin
    if (!Rst_n) rr_q <= RR_WR;
    else        rr_q <= rr_nxt;
  end

  // Round-robin grant of the single RAM port; pointer moves past whoever was granted
  always_comb begin
    wr_gnt = 1'b0;
    rd_gnt = 1'b0;
    rr_nxt = rr_q;
    if (wr_elig && (!rd_elig || rr_q == RR_WR)) begin
      wr_gnt = 1'b1;
      rr_nxt = RR_RD;
    end else if (rd_elig) begin
      rd_gnt = 1'b1;
      rr_nxt = RR_WR;
    end
  end

  // RAM write port plus read data pipe; stage 0 is the RAM read register
  always_ff @(posedge Clk) begin
    if (wr_gnt) mem[wr_head[WR_W-1 -: ADDR_WIDTH]] <= wr_head[DDR_DATA_W-1:0];
    if (rd_gnt) rd_dat_q[0] <= mem[rd_head];
    for (int i = 1; i < RD_LATENCY; i++) rd_dat_q[i] <= rd_dat_q[i-1];
  end

  // Read valid token pipe; reset squashes anything in flight
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      rd_vld_q <= '0;
    end else begin
      rd_vld_q[0] <= rd_gnt;
      for (int i = 1; i < RD_LATENCY; i++) rd_vld_q[i] <= rd_vld_q[i-1];
    end
  end

  assign ddr_rd_resp_valid = rd_vld_q[RD_LATENCY-1];
  assign ddr_rd_resp_data  = rd_dat_q[RD_LATENCY-1];

  // Free-running statistics, wrapping modulo 2^32
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      stat_wr_cnt   <= '0;
      stat_rd_cnt   <= '0;
      stat_drop_cnt <= '0;
    end else begin
      stat_wr_cnt   <= stat_wr_cnt + 32'(wr_gnt);
      stat_rd_cnt   <= stat_rd_cnt + 32'(ddr_rd_resp_valid);
      stat_drop_cnt <= stat_drop_cnt + 32'(wr_drop) + 32'(rd_drop);
    end
  end

endmodule
